// File: rtl/sfence_flush_queue.sv
// rtl/sfence_flush_queue.sv - in-order SFENCE.VMA buffer issuing committed TLB flush requests
module sfence_flush_queue #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned VLEN       = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [VLEN-1:0]              vaddr_i,
    input  logic [ASID_WIDTH-1:0]        asid_i,
    input  logic                         rs1_zero_i,
    input  logic                         rs2_zero_i,
    input  logic                         commit_i,
    output logic                         tlb_flush_valid_o,
    input  logic                         tlb_flush_ready_i,
    output logic [VLEN-1:0]              tlb_flush_vaddr_o,
    output logic [ASID_WIDTH-1:0]        tlb_flush_asid_o,
    output logic [1:0]                   tlb_flush_mode_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Entries between rd and cmt are committed; between cmt and wr are speculative.
    ptr_t rd_ptr_q, cmt_ptr_q, wr_ptr_q;
    ptr_t rd_ptr_n, cmt_ptr_n, wr_ptr_n;
    cnt_t count_q, cmt_cnt_q;
    cnt_t count_n, cmt_cnt_n;

    logic [VLEN-1:0]       vaddr_q [DEPTH];
    logic [ASID_WIDTH-1:0] asid_q  [DEPTH];
    logic [1:0]            mode_q  [DEPTH];

    logic enq, deq, cmt;

    assign ready_o           = (count_q < cnt_t'(DEPTH));
    assign tlb_flush_valid_o = (cmt_cnt_q != '0);
    assign enq               = valid_i & ready_o & ~flush_i;
    assign deq               = tlb_flush_valid_o & tlb_flush_ready_i;
    assign cmt               = commit_i & (count_q != cmt_cnt_q);

    always_comb begin
        cmt_cnt_n = cmt_cnt_q + cnt_t'(cmt) - cnt_t'(deq);
        cmt_ptr_n = cmt ? ptr_inc(cmt_ptr_q) : cmt_ptr_q;
        rd_ptr_n  = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_n  = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_n   = count_q + cnt_t'(enq) - cnt_t'(deq);
        // Flush sees this cycle's commit, so a same-cycle commit survives.
        if (flush_i) begin
            wr_ptr_n = cmt_ptr_n;
            count_n  = cmt_cnt_n;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            cmt_cnt_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_n;
            cmt_ptr_q <= cmt_ptr_n;
            wr_ptr_q  <= wr_ptr_n;
            count_q   <= count_n;
            cmt_cnt_q <= cmt_cnt_n;
        end
    end

    // Payload needs no reset: outputs are gated by the valid flag.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            vaddr_q[wr_ptr_q] <= vaddr_i;
            asid_q[wr_ptr_q]  <= asid_i;
            mode_q[wr_ptr_q]  <= {~rs1_zero_i, ~rs2_zero_i};
        end
    end

    assign tlb_flush_vaddr_o = tlb_flush_valid_o ? vaddr_q[rd_ptr_q] : '0;
    assign tlb_flush_asid_o  = tlb_flush_valid_o ? asid_q[rd_ptr_q]  : '0;
    assign tlb_flush_mode_o  = tlb_flush_valid_o ? mode_q[rd_ptr_q]  : '0;
    assign count_o           = count_q;
    assign busy_o            = (count_q != '0);

endmodule
